// File: rtl/hasti_sram_pkg.sv
// Shared HASTI (AHB-Lite) encodings for the SRAM responder: transfer types, responses,
// transfer sizes and the byte-strobe helper.
package pk_hasti;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_t;

  typedef enum logic {
    HrespOkay  = 1'b0,
    HrespError = 1'b1
  } hresp_t;

  typedef enum logic [1:0] {
    StOk,
    StErr1,
    StErr2
  } err_state_t;

  localparam logic [2:0] HsizeByte = 3'd0;
  localparam logic [2:0] HsizeHalf = 3'd1;
  localparam logic [2:0] HsizeWord = 3'd2;

  // Unaligned low bits are dropped to the size alignment; sizes above word act as word.
  function automatic logic [3:0] byte_enables(input logic [1:0] addr, input logic [2:0] size);
    logic [3:0] be;
    case (size)
      HsizeByte: be = 4'b0001 << addr;
      HsizeHalf: be = addr[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/hasti_sram_mem.sv
// Single-port synchronous 32-bit RAM with per-byte write enables and a registered read.
module hasti_sram_mem #(
  parameter int unsigned ADDR_BITS = 12,
  parameter string       INIT_FILE = ""
) (
  input  logic                 i_clk,
  input  logic                 i_cs,
  input  logic [3:0]           i_we,
  input  logic [ADDR_BITS-3:0] i_addr,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata
);

  localparam int unsigned Depth = 2 ** (ADDR_BITS - 2);

  logic [31:0] r_mem [Depth];
  logic [31:0] r_rdata;

  // Memory array carries no reset; an access with no strobes is a read.
  always_ff @(posedge i_clk) begin
    if (i_cs) begin
      if (i_we == 4'b0000) begin
        r_rdata <= r_mem[i_addr];
      end
      for (int i = 0; i < 4; i++) begin
        if (i_we[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/hasti_sram.sv
// AHB-Lite SRAM responder with a one-entry write buffer and read bypass, zero wait states.
// Define HASTI_SRAM_ALIGN_CHECK_EN to answer misaligned or oversized transfers with ERROR.
module hasti_sram
  import pk_hasti::*;
#(
  parameter int unsigned ADDR_BITS = 12,
  parameter string       INIT_FILE = ""
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned WordBits = ADDR_BITS - 2;

  logic                w_acc;
  logic                w_acc_ok;
  logic                w_rd;
  logic                w_wdp;
  logic                w_drain;
  logic                w_direct;
  logic                w_load;
  logic                w_mem_cs;
  logic [3:0]          w_mem_we;
  logic [WordBits-1:0] w_mem_addr;
  logic [31:0]         w_mem_wdata;
  logic [31:0]         w_mem_rdata;
  logic [31:0]         w_merged;

  logic                r_dp_valid;
  logic                r_dp_write;
  logic [WordBits-1:0] r_dp_word;
  logic [3:0]          r_dp_be;

  logic                r_wb_valid;
  logic [WordBits-1:0] r_wb_word;
  logic [3:0]          r_wb_be;
  logic [31:0]         r_wb_data;

  logic w_unused;
  assign w_unused = ^{hburst, hprot, hmastlock, haddr[31:ADDR_BITS]};

  assign w_acc = hsel & hready &
                 ((htrans == HtransNonseq) | (htrans == HtransSeq));

`ifdef HASTI_SRAM_ALIGN_CHECK_EN
  logic       w_misalign;
  err_state_t r_err_state;
  err_state_t w_err_next;

  always_comb begin
    w_misalign = 1'b0;
    if (hsize > HsizeWord) begin
      w_misalign = 1'b1;
    end else if (hsize == HsizeHalf) begin
      w_misalign = haddr[0];
    end else if (hsize == HsizeWord) begin
      w_misalign = |haddr[1:0];
    end
  end

  assign w_acc_ok = w_acc & ~w_misalign;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_err_state <= StOk;
    end else begin
      r_err_state <= w_err_next;
    end
  end

  // Cycle 1 stalls with ERROR, cycle 2 releases with ERROR and may take a new address.
  always_comb begin
    w_err_next = StOk;
    hreadyout  = 1'b1;
    hresp      = HrespOkay;
    case (r_err_state)
      StErr1: begin
        w_err_next = StErr2;
        hreadyout  = 1'b0;
        hresp      = HrespError;
      end
      StErr2: begin
        w_err_next = (w_acc & w_misalign) ? StErr1 : StOk;
        hresp      = HrespError;
      end
      default: begin
        w_err_next = (w_acc & w_misalign) ? StErr1 : StOk;
      end
    endcase
  end
`else
  assign w_acc_ok  = w_acc;
  assign hreadyout = 1'b1;
  assign hresp     = HrespOkay;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_word  <= '0;
      r_dp_be    <= 4'b0000;
    end else if (hready) begin
      r_dp_valid <= w_acc_ok;
      if (w_acc_ok) begin
        r_dp_write <= hwrite;
        r_dp_word  <= haddr[ADDR_BITS-1:2];
        r_dp_be    <= byte_enables(haddr[1:0], hsize);
      end
    end
  end

  // Port priority: address-phase read, then buffer drain, then direct commit of arriving
  // write data. Write data only parks in the buffer when a read holds the port, so
  // back-to-back writes followed by a read never overwrite an undrained entry.
  assign w_rd     = w_acc_ok & ~hwrite;
  assign w_wdp    = r_dp_valid & r_dp_write & hready;
  assign w_drain  = ~w_rd & r_wb_valid;
  assign w_direct = w_wdp & ~w_rd & ~r_wb_valid;
  assign w_load   = w_wdp & ~w_direct;

  assign w_mem_cs    = w_rd | w_drain | w_direct;
  assign w_mem_we    = w_drain ? r_wb_be : (w_direct ? r_dp_be : 4'b0000);
  assign w_mem_addr  = w_rd ? haddr[ADDR_BITS-1:2] : (w_drain ? r_wb_word : r_dp_word);
  assign w_mem_wdata = w_drain ? r_wb_data : hwdata;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_wb_valid <= 1'b0;
      r_wb_word  <= '0;
      r_wb_be    <= 4'b0000;
      r_wb_data  <= 32'h0;
    end else if (w_load) begin
      r_wb_valid <= 1'b1;
      r_wb_word  <= r_dp_word;
      r_wb_be    <= r_dp_be;
      r_wb_data  <= hwdata;
    end else if (w_drain) begin
      r_wb_valid <= 1'b0;
    end
  end

  hasti_sram_mem #(
    .ADDR_BITS (ADDR_BITS),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .i_clk   (hclk),
    .i_cs    (w_mem_cs),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );

  always_comb begin
    w_merged = w_mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (r_wb_valid && (r_wb_word == r_dp_word) && r_wb_be[i]) begin
        w_merged[8*i +: 8] = r_wb_data[8*i +: 8];
      end
    end
    hrdata = (r_dp_valid & ~r_dp_write) ? w_merged : 32'h0;
  end

endmodule
